// File: rtl/ps2_pkg.sv
// Shared types and frame layout for the PS/2 receive path.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_W = 11;
    localparam int unsigned START_BIT   = 0;
    localparam int unsigned DATA_LSB    = 1;
    localparam int unsigned DATA_MSB    = 8;
    localparam int unsigned PARITY_BIT  = 9;
    localparam int unsigned STOP_BIT    = 10;

    typedef enum logic [1:0] {IDLE, DPS, LOAD} ps2_state_e;

    // Start low, stop high, odd parity over data plus parity bit.
    function automatic logic frame_ok(input logic [PS2_FRAME_W-1:0] f);
        return !f[START_BIT] && f[STOP_BIT] && (^f[PARITY_BIT:DATA_LSB]);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes ps2c/ps2d, glitch-filters ps2c and emits a one-cycle pulse per filtered falling edge.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall,
    output logic d_sync
);

    logic [1:0]            c_sync_q;
    logic [1:0]            d_sync_q;
    logic [FILTER_LEN-1:0] filter_q;
    logic [FILTER_LEN-1:0] filter_d;
    logic                  fc_q;
    logic                  fc_d;

    // Level only changes once the whole window agrees; mixed windows hold.
    always_comb begin
        filter_d = {c_sync_q[1], filter_q[FILTER_LEN-1:1]};
        fc_d     = fc_q;
        if (&filter_q) begin
            fc_d = 1'b1;
        end else if (~|filter_q) begin
            fc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            filter_q <= '1;
            fc_q     <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c};
            d_sync_q <= {d_sync_q[0], ps2d};
            filter_q <= filter_d;
            fc_q     <= fc_d;
        end
    end

    assign fall   = fc_q & ~fc_d;
    assign d_sync = d_sync_q[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver. Define PS2_FRAME_CHECK_EN to reject frames with bad
// start/stop/parity via frame_err instead of rx_done_tick.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 20000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_en,
    input  logic                   ps2c,
    input  logic                   ps2d,
    output logic                   rx_done_tick,
    output logic [PS2_FRAME_W-1:0] dout,
    output logic                   frame_err
);

    localparam int unsigned    TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    ps2_state_e             state_q;
    logic [3:0]             n_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [PS2_FRAME_W-1:0] frame_q;
    logic [PS2_FRAME_W-1:0] frame_shift;
    logic                   fall;
    logic                   d_sync;
    logic                   last_ok;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .ps2c  (ps2c),
        .ps2d  (ps2d),
        .fall  (fall),
        .d_sync(d_sync)
    );

    assign frame_shift = {d_sync, frame_q[PS2_FRAME_W-1:1]};

`ifdef PS2_FRAME_CHECK_EN
    assign last_ok = frame_ok(frame_shift);
`else
    assign last_ok = 1'b1;
`endif

    // The result pulse is registered on the last edge so it coincides with the LOAD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            tmo_q        <= '0;
            frame_q      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fall && rx_en) begin
                        frame_q <= frame_shift;
                        n_q     <= 4'd9;
                        tmo_q   <= '0;
                        state_q <= DPS;
                    end
                end
                DPS: begin
                    if (fall) begin
                        frame_q <= frame_shift;
                        tmo_q   <= '0;
                        if (n_q == 4'd0) begin
                            state_q      <= LOAD;
                            rx_done_tick <= last_ok;
                            frame_err    <= !last_ok;
                        end else begin
                            n_q <= n_q - 4'd1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        frame_err <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end
                LOAD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dout = frame_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: 1 MHz clk, 12.5 kHz ps2c (80 clk per PS/2 bit).
`timescale 1ns/1ps
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT    = 500;
`ifdef PS2_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_en = 1'b0;
    logic        ps2c  = 1'b1;
    logic        ps2d  = 1'b1;
    logic        rx_done_tick;
    logic        frame_err;
    logic [10:0] dout;

    typedef struct packed {
        logic        is_err;
        logic [10:0] dout;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    int          checks    = 0;
    int          failures  = 0;
    int          tick_cnt  = 0;
    int          err_cnt   = 0;
    int          fall_cnt  = 0;
    logic [10:0] mdl_frame = '0;
    logic        mdl_busy  = 1'b0;
    int          mdl_cnt   = 0;
    int          t0, e0, f0;

    ps2_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_en       (rx_en),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .rx_done_tick(rx_done_tick),
        .dout        (dout),
        .frame_err   (frame_err)
    );

    always #500 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pop one expectation per result pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dut.fall) fall_cnt++;
            if (rx_done_tick) tick_cnt++;
            if (frame_err) err_cnt++;
            if (rx_done_tick || frame_err) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_evt", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("evt_err", 32'(frame_err), 32'(mon_e.is_err));
                    check("evt_tick", 32'(rx_done_tick), 32'(!mon_e.is_err));
                    check("evt_dout", 32'(dout), 32'(mon_e.dout));
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] data, input logic par_flip, input int n_edges,
                              input bit glitch, input int drop_en_at);
        logic [10:0] bits;
        sb_t         e;
        bits = {1'b1, ~(^data) ^ par_flip, data, 1'b0};
        for (int i = 0; i < n_edges; i++) begin
            @(negedge clk) ps2d = bits[i];
            if (glitch) begin
                wait_clk(5); ps2c = 1'b0; wait_clk(3); ps2c = 1'b1; wait_clk(12);
            end else begin
                wait_clk(20);
            end
            ps2c = 1'b0;
            if (mdl_busy || rx_en) begin
                mdl_frame = {bits[i], mdl_frame[10:1]};
                mdl_busy  = 1'b1;
                mdl_cnt++;
                if (mdl_cnt == 11) begin
                    e.dout   = mdl_frame;
                    e.is_err = CHK && par_flip;
                    sb_q.push_back(e);
                    mdl_busy = 1'b0;
                    mdl_cnt  = 0;
                end
            end
            wait_clk(40);
            ps2c = 1'b1;
            wait_clk(20);
            if (i == drop_en_at) rx_en = 1'b0;
        end
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        wait_clk(3);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_tick", 32'(rx_done_tick), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        wait_clk(20);

        // Valid 0x1C frame
        rx_en = 1'b1;
        send_frame(8'h1C, 1'b0, 11, 1'b0, -1);
        wait_clk(30);
        check("t1_drain", sb_q.size(), 32'd0);
        check("t1_dout", 32'(dout), 32'h438);
        check("t1_hi_nib", 32'(dout[8:5]), 32'h1);
        check("t1_lo_nib", 32'(dout[4:1]), 32'hC);
        check("t1_no_err", err_cnt, 32'd0);

        // Glitches inside each high phase
        f0 = fall_cnt;
        send_frame(8'hF0, 1'b0, 11, 1'b1, -1);
        wait_clk(30);
        check("t2_falls", fall_cnt - f0, 32'd11);
        check("t2_data", 32'(dout[8:1]), 32'hF0);
        check("t2_drain", sb_q.size(), 32'd0);

        // Timeout after 5 edges, then a clean 0x29
        t0 = tick_cnt; e0 = err_cnt;
        send_frame(8'h29, 1'b0, 5, 1'b0, -1);
        e.is_err = 1'b1;
        e.dout   = mdl_frame;
        sb_q.push_back(e);
        mdl_busy = 1'b0;
        mdl_cnt  = 0;
        wait_clk(TIMEOUT + 10);
        check("t3_err", err_cnt - e0, 32'd1);
        check("t3_tick", tick_cnt - t0, 32'd0);
        check("t3_drain", sb_q.size(), 32'd0);
        send_frame(8'h29, 1'b0, 11, 1'b0, -1);
        wait_clk(30);
        check("t3_data", 32'(dout[8:1]), 32'h29);
        check("t3_drain2", sb_q.size(), 32'd0);

        // Receive disabled throughout, then dropped after edge 3
        rx_en = 1'b0;
        t0 = tick_cnt;
        send_frame(8'hA5, 1'b0, 11, 1'b0, -1);
        wait_clk(30);
        check("t4_no_tick", tick_cnt - t0, 32'd0);
        check("t4_idle", 32'(dut.state_q), 32'(IDLE));
        rx_en = 1'b1;
        t0 = tick_cnt;
        send_frame(8'h3A, 1'b0, 11, 1'b0, 2);
        wait_clk(30);
        check("t4_drop_tick", tick_cnt - t0, 32'd1);
        check("t4_drop_data", 32'(dout[8:1]), 32'h3A);
        check("t4_drain", sb_q.size(), 32'd0);
        rx_en = 1'b1;

        // Reset after edge 6
        send_frame(8'h77, 1'b0, 6, 1'b0, -1);
        rst_n     = 1'b0;
        mdl_frame = '0;
        mdl_busy  = 1'b0;
        mdl_cnt   = 0;
        wait_clk(3);
        check("t5_dout", 32'(dout), 32'd0);
        check("t5_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        t0 = tick_cnt; e0 = err_cnt;
        wait_clk(TIMEOUT + 10);
        check("t5_no_tick", tick_cnt - t0, 32'd0);
        check("t5_no_err", err_cnt - e0, 32'd0);
        send_frame(8'h1C, 1'b0, 11, 1'b0, -1);
        wait_clk(30);
        check("t5_dout2", 32'(dout), 32'h438);

        // Bad parity
        t0 = tick_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 11, 1'b0, -1);
        wait_clk(30);
        check("t6_dout", 32'(dout), 32'h638);
        check("t6_err", err_cnt - e0, 32'(CHK));
        check("t6_tick", tick_cnt - t0, 32'(!CHK));

        wait_clk(20);
        check("final_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
